// File: rtl/tx_timer_pkg.sv
// Shared types and constants for the I2C slave transmit timer.
package tx_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_ACK_WAIT  = 2'd3
  } tx_state_e;

  localparam logic SDA_RELEASE = 1'b1;
  localparam logic ACK_LEVEL   = 1'b0;
  localparam int   CNT_W       = 4;

endpackage

// File: rtl/tx_timer_if.sv
// Bus-event / byte-load / status bundle between the I2C front end and tx_timer.
interface tx_timer_if #(
  parameter int NUM_BITS = 8
) ();
  logic                start_found;
  logic                stop_found;
  logic                rising_edge_found;
  logic                falling_edge_found;
  logic                sda_in;
  logic                tx_load;
  logic [NUM_BITS-1:0] tx_data;
  logic                sda_out;
  logic                load_ready;
  logic                tx_busy;
  logic                ack_received;
  logic                nack_received;
  logic                tx_underrun;

  modport master (
    output start_found, stop_found, rising_edge_found, falling_edge_found,
           sda_in, tx_load, tx_data,
    input  sda_out, load_ready, tx_busy, ack_received, nack_received, tx_underrun
  );

  modport slave (
    input  start_found, stop_found, rising_edge_found, falling_edge_found,
           sda_in, tx_load, tx_data,
    output sda_out, load_ready, tx_busy, ack_received, nack_received, tx_underrun
  );
endinterface

// File: rtl/tx_timer_flex_counter.sv
// Clearable up-counter; rollover_flag is high while the count equals rollover_val.
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic         rollover_flag
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = (count_q == rollover_val) ? W'(1) : count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign rollover_flag = (count_q == rollover_val);
endmodule

// File: rtl/tx_timer.sv
// Slave-transmitter bit timer: shifts a held byte onto SDA on SCL falls, then samples the master ACK.
module tx_timer
  import tx_timer_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input logic        clk,
  input logic        n_rst,
  tx_timer_if.slave  bus
);
  tx_state_e           state_q, state_d;
  logic                sda_q, sda_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                acked_q, acked_d;
  logic                ack_q, ack_d;
  logic                nack_q, nack_d;
  logic                unr_q, unr_d;
  logic                cnt_en, cnt_clr, byte_done;
  logic                stop, start, fall, rise;

  // Bus conditions outrank SCL edges; STOP outranks START.
  assign stop  = bus.stop_found;
  assign start = bus.start_found & ~bus.stop_found;
  assign fall  = bus.falling_edge_found & ~bus.start_found & ~bus.stop_found;
  assign rise  = bus.rising_edge_found  & ~bus.start_found & ~bus.stop_found;

  flex_counter #(.W(CNT_W)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clr),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(NUM_BITS)),
    .rollover_flag(byte_done)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop)
      state_d = ST_IDLE;
    else if (start)
      state_d = ST_WAIT_BYTE;
    else begin
      case (state_q)
        ST_WAIT_BYTE: if (fall && hold_full_q) state_d = ST_SHIFT;
        ST_SHIFT:     if (fall && byte_done)   state_d = ST_ACK_WAIT;
        ST_ACK_WAIT:  if (rise) state_d = (bus.sda_in == ACK_LEVEL) ? ST_WAIT_BYTE : ST_IDLE;
        default:      state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_d       = sda_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acked_d     = acked_q;
    ack_d       = 1'b0;
    nack_d      = 1'b0;
    unr_d       = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;

    if (bus.tx_load && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    if (stop) begin
      sda_d       = SDA_RELEASE;
      hold_d      = '0;
      hold_full_d = 1'b0;
      acked_d     = 1'b0;
      cnt_clr     = 1'b1;
    end else if (start) begin
      sda_d   = SDA_RELEASE;
      acked_d = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_BYTE: if (fall) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            sda_d       = hold_q[NUM_BITS-1];
            hold_full_d = 1'b0;
            cnt_en      = 1'b1;
          end else if (acked_q) begin
            // Only a byte slot following an ACK is a real underrun.
            unr_d = 1'b1;
          end
        end
        ST_SHIFT: if (fall) begin
          if (byte_done) begin
            sda_d   = SDA_RELEASE;
            cnt_clr = 1'b1;
          end else begin
            shift_d = {shift_q[NUM_BITS-2:0], 1'b0};
            sda_d   = shift_q[NUM_BITS-2];
            cnt_en  = 1'b1;
          end
        end
        ST_ACK_WAIT: if (rise) begin
          if (bus.sda_in == ACK_LEVEL) begin
            ack_d   = 1'b1;
            acked_d = 1'b1;
          end else begin
            nack_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sda_q       <= SDA_RELEASE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      acked_q     <= 1'b0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      sda_q       <= sda_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acked_q     <= acked_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      unr_q       <= unr_d;
    end
  end

  assign bus.sda_out       = sda_q;
  assign bus.load_ready    = ~hold_full_q;
  assign bus.tx_busy       = (state_q == ST_SHIFT) || (state_q == ST_ACK_WAIT);
  assign bus.ack_received  = ack_q;
  assign bus.nack_received = nack_q;
  assign bus.tx_underrun   = unr_q;
endmodule
